// File: rtl/adder_16.sv
// adder_16: 16-bit ripple-carry adder built from half/full adder cells.
// Combinational sum on `out`, plus a registered copy of the sum with
// unsigned carry and signed overflow flags.

// half_adder: single-bit sum and carry of two inputs
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

// full_adder: two half adders; carry-out is majority(a, b, cin)
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s1), .o_c(w_c1));
  half_adder u_ha1 (.i_a(w_s1), .i_b(i_c), .o_s(o_s),  .o_c(w_c2));

  assign o_c = w_c1 | w_c2;
endmodule

module adder_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic [15:0] out_q,
  output logic        carry_q,
  output logic        ovf_q
);
  // w_c[i] is the carry into bit i; there is no carry-in port, so w_c[0] is tied low
  logic [16:0] w_c;
  logic [15:0] w_sum;
  logic        w_carry;
  logic        w_ovf;

  logic [15:0] r_sum;
  logic        r_carry;
  logic        r_ovf;

  assign w_c[0] = 1'b0;

  // ripple chain of 16 full adders, LSB first
  for (genvar i = 0; i < 16; i++) begin : g_bit
    full_adder u_fa (
      .i_a (a[i]),
      .i_b (b[i]),
      .i_c (w_c[i]),
      .o_s (w_sum[i]),
      .o_c (w_c[i+1])
    );
  end

  // signed overflow: carry into the sign bit differs from carry out of it
  assign w_carry = w_c[16];
  assign w_ovf   = w_c[16] ^ w_c[15];
  assign out     = w_sum;

  // capture sum and flags each cycle; async reset clears them immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= 16'h0000;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
    end
  end

  assign out_q   = r_sum;
  assign carry_q = r_carry;
  assign ovf_q   = r_ovf;
endmodule

// File: tb/tb_adder_16.sv
// tb_adder_16: directed and random checks of adder_16 sum, registers and reset.
module tb_adder_16;
  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic [15:0] out_q;
  logic        carry_q;
  logic        ovf_q;

  int checks = 0;
  int errors = 0;

  logic [16:0] g_full;
  logic        g_ovf;

  adder_16 dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .out     (out),
    .out_q   (out_q),
    .carry_q (carry_q),
    .ovf_q   (ovf_q)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = 16'h0000;
    b   = 16'h0000;
    #5;
    check16("reset_out_q", out_q, 16'h0000);
    check1("reset_carry", carry_q, 1'b0);
    check1("reset_ovf", ovf_q, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // combinational checks, 10 units settle
    a = 16'h0000; b = 16'h0000; #10;
    check16("comb_0_0", out, 16'h0000);
    a = 16'h0001; b = 16'h0000; #10;
    check16("comb_1_0", out, 16'h0001);
    a = 16'h0001; b = 16'h0001; #10;
    check16("comb_1_1", out, 16'h0002);
    a = 16'h000F; b = 16'h000F; #10;
    check16("comb_f_f", out, 16'h001E);

    // 0x4000 + 0x4000: signed overflow, no carry
    @(posedge clk); #1;
    a = 16'h4000; b = 16'h4000; #10;
    check16("ovf_pos_out", out, 16'h8000);
    @(posedge clk); #1;
    check16("ovf_pos_out_q", out_q, 16'h8000);
    check1("ovf_pos_carry", carry_q, 1'b0);
    check1("ovf_pos_ovf", ovf_q, 1'b1);

    // 0x8000 + 0x8000: wraps to 0, carry and overflow
    a = 16'h8000; b = 16'h8000; #10;
    check16("ovf_neg_out", out, 16'h0000);
    @(posedge clk); #1;
    check16("ovf_neg_out_q", out_q, 16'h0000);
    check1("ovf_neg_carry", carry_q, 1'b1);
    check1("ovf_neg_ovf", ovf_q, 1'b1);

    // 0xFFFF + 0x0001: carry, no signed overflow
    a = 16'hFFFF; b = 16'h0001; #10;
    check16("wrap_out", out, 16'h0000);
    @(posedge clk); #1;
    check16("wrap_out_q", out_q, 16'h0000);
    check1("wrap_carry", carry_q, 1'b1);
    check1("wrap_ovf", ovf_q, 1'b0);

    // operand change between edges: out moves, out_q holds
    a = 16'h0002; b = 16'h0003; #5;
    check16("between_out", out, 16'h0005);
    check16("between_out_q", out_q, 16'h0000);
    @(posedge clk); #1;
    check16("between_out_q_next", out_q, 16'h0005);

    // reset mid-operation
    a = 16'h1234; b = 16'h1111; #5;
    @(posedge clk); #1;
    check16("rst_load_out_q", out_q, 16'h2345);
    check16("rst_load_out", out, 16'h2345);
    #4;
    rst = 1'b1;
    #1;
    check16("rst_mid_out_q", out_q, 16'h0000);
    check1("rst_mid_carry", carry_q, 1'b0);
    check1("rst_mid_ovf", ovf_q, 1'b0);
    check16("rst_mid_out", out, 16'h2345);
    @(posedge clk); #1;
    check16("rst_held_out_q", out_q, 16'h0000);
    check16("rst_held_out", out, 16'h2345);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check16("rst_release_no_edge", out_q, 16'h0000);
    @(posedge clk); #1;
    check16("rst_release_edge", out_q, 16'h2345);

    // random pairs against golden model
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom());
      b = 16'($urandom());
      g_full = {1'b0, a} + {1'b0, b};
      g_ovf  = (a[15] == b[15]) && (g_full[15] != a[15]);
      #10;
      check16("rand_out", out, g_full[15:0]);
      @(posedge clk); #1;
      check16("rand_out_q", out_q, g_full[15:0]);
      check1("rand_carry", carry_q, g_full[16]);
      check1("rand_ovf", ovf_q, g_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
